// File: rtl/fetch_stage_pkg.sv
// Shared handoff types between fetch and decode.
package Uop;

    localparam int FETCH_XLEN  = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           instr;
    } fetch_t;

    // Sequential fetch address, wrapping modulo 2^32.
    function automatic logic [FETCH_XLEN-1:0] nextPc(input logic [FETCH_XLEN-1:0] pc);
        return pc + FETCH_XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction bus plus decode handshake seen by the fetch stage.
interface fetch_stage_if #(
    parameter int ID_W = 2
);
    import Uop::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [31:0]     imem_req_addr;
    logic [ID_W-1:0] imem_req_id;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic [ID_W-1:0] imem_resp_id;
    logic            imem_resp_ready;
    logic            d_valid;
    logic            d_stall;
    fetch_t          d_uop;

    modport master (
        output imem_req_valid, imem_req_addr, imem_req_id, imem_resp_ready, d_valid, d_uop,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_id, d_stall
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, imem_req_id, imem_resp_ready, d_valid, d_uop,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_id, d_stall
    );

endinterface

// File: rtl/fetch_stage_buffer.sv
// In-order ring of fetched instructions with separate allocate, fill and pop pointers.
module fetch_buffer
    import Uop::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             alloc_i,
    input  logic [31:0]      allocPc_i,
    input  logic             fill_i,
    input  logic [31:0]      fillData_i,
    input  logic             pop_i,
    output logic             headValid_o,
    output fetch_t           headUop_o,
    output logic [CNT_W-1:0] freeCnt_o,
    output logic [CNT_W-1:0] unfilledCnt_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]      pcMem    [DEPTH];
    logic [31:0]      instrMem [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PTR_W-1:0] head_q, head_d, fill_q, fill_d, tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, unfilled_q, unfilled_d;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        filled_d   = filled_q;
        head_d     = head_q;
        fill_d     = fill_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
        unfilled_d = unfilled_q + CNT_W'(alloc_i) - CNT_W'(fill_i);
        if (alloc_i) begin
            filled_d[tail_q] = 1'b0;
            tail_d           = inc(tail_q);
        end
        if (fill_i) begin
            filled_d[fill_q] = 1'b1;
            fill_d           = inc(fill_q);
        end
        if (pop_i) begin
            filled_d[head_q] = 1'b0;
            head_d           = inc(head_q);
        end
        // A flush drops everything, including same-cycle allocate/fill/pop.
        if (clear_i) begin
            filled_d   = '0;
            head_d     = '0;
            fill_d     = '0;
            tail_d     = '0;
            cnt_d      = '0;
            unfilled_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filled_q   <= '0;
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            unfilled_q <= '0;
        end else begin
            filled_q   <= filled_d;
            head_q     <= head_d;
            fill_q     <= fill_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            unfilled_q <= unfilled_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_i) pcMem[tail_q] <= allocPc_i;
        if (fill_i)  instrMem[fill_q] <= fillData_i;
    end

    assign headValid_o   = filled_q[head_q];
    assign headUop_o     = '{pc: pcMem[head_q], instr: instrMem[head_q]};
    assign freeCnt_o     = CNT_W'(DEPTH) - cnt_q + CNT_W'(pop_i);
    assign unfilledCnt_o = unfilled_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, request issue with credit accounting, and flush-time drop counting.
module fetch_stage
    import Uop::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter int          ID_W     = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    fetch_stage_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] dropCnt_q, dropCnt_d;
    logic [ID_W-1:0]  reqId_q, reqId_d;
    logic [CNT_W-1:0] freeCnt, unfilledCnt;
    logic             headValid, popFire, reqFire, respDrop, respFill;
    fetch_t           headUop;
    logic             unusedRespId;

    assign unusedRespId = ^bus.imem_resp_id;

    assign popFire  = headValid && !bus.d_stall && !redirect_valid;
    assign respDrop = bus.imem_resp_valid && (dropCnt_q != '0);
    assign respFill = bus.imem_resp_valid && (dropCnt_q == '0) && (unfilledCnt != '0);

    // Entries plus responses still owed to a flushed stream may never exceed DEPTH.
    assign bus.imem_req_valid  = (freeCnt > dropCnt_q) && !redirect_valid && !rst;
    assign bus.imem_req_addr   = pc_q;
    assign bus.imem_req_id     = reqId_q;
    assign bus.imem_resp_ready = 1'b1;
    assign bus.d_valid         = headValid;
    assign bus.d_uop           = headUop;
    assign reqFire             = bus.imem_req_valid && bus.imem_req_ready;

    always_comb begin
        pc_d      = pc_q;
        reqId_d   = reqId_q;
        dropCnt_d = dropCnt_q - CNT_W'(respDrop);
        if (reqFire) begin
            pc_d    = nextPc(pc_q);
            reqId_d = reqId_q + 1'b1;
        end
        // Every unfilled entry becomes a response to discard, less one filled this cycle.
        if (redirect_valid) begin
            pc_d      = redirect_pc;
            dropCnt_d = dropCnt_q - CNT_W'(respDrop) + unfilledCnt - CNT_W'(respFill);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            dropCnt_q <= '0;
            reqId_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            dropCnt_q <= dropCnt_d;
            reqId_q   <= reqId_d;
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_buffer (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (redirect_valid),
        .alloc_i       (reqFire),
        .allocPc_i     (pc_q),
        .fill_i        (respFill),
        .fillData_i    (bus.imem_resp_data),
        .pop_i         (popFire),
        .headValid_o   (headValid),
        .headUop_o     (headUop),
        .freeCnt_o     (freeCnt),
        .unfilledCnt_o (unfilledCnt)
    );

endmodule
